// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - program counter and fetch sequencer with start/done handshake
//
// Optional feature macro: PC_FETCH_ICOUNT_EN (adds the icount output)
//
// Ports:
//   icount      out 16      instructions executed in the current/last run (PC_FETCH_ICOUNT_EN only)
//   clk         in  1       system clock, rising edge
//   reset       in  1       synchronous active-high reset
//   start       in  1       run request, level-sampled
//   halt        in  1       decoded halt for the instruction at pc
//   br_taken    in  1       branch condition true for the instruction at pc
//   br_rel      in  1       1 = relative branch, 0 = absolute branch through the LUT
//   br_lut_idx  in  LUT_AW  LUT index for an absolute branch
//   br_off      in  OFF_W   signed relative branch offset
//   lut_we      in  1       LUT write enable (IDLE/HALTED only)
//   lut_waddr   in  LUT_AW  LUT write address
//   lut_wdata   in  PC_W    LUT write data
//   pc          out PC_W    current instruction address
//   running     out 1       high while in RUN
//   done        out 1       program finished (halt or wrap fault)
//   fault       out 1       pc wrapped past its top address without a halt
module pc_fetch_seq #(
   parameter int PC_W       = 10,
   parameter int LUT_AW     = 4,
   parameter int OFF_W      = 6,
   parameter int START_ADDR = 0
) (
`ifdef PC_FETCH_ICOUNT_EN
   output logic [15:0]       icount,
`endif
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt,
   input  logic              br_taken,
   input  logic              br_rel,
   input  logic [LUT_AW-1:0] br_lut_idx,
   input  logic [OFF_W-1:0]  br_off,
   input  logic              lut_we,
   input  logic [LUT_AW-1:0] lut_waddr,
   input  logic [PC_W-1:0]   lut_wdata,
   output logic [PC_W-1:0]   pc,
   output logic              running,
   output logic              done,
   output logic              fault
);

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, HALTED} state_t;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc_nxt;
   logic              running_nxt, done_nxt, fault_nxt;
   logic [PC_W-1:0]   lut [0:2**LUT_AW-1];
   logic [PC_W-1:0]   off_ext;
   logic              lut_open;
   logic              start_accept;

   // Relative offsets are two's complement; the add wraps modulo 2^PC_W.
   assign off_ext      = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};
   assign lut_open     = (state == IDLE) || (state == HALTED);
   assign start_accept = lut_open && start;

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      running_nxt = running;
      done_nxt    = done;
      fault_nxt   = fault;
      case (state)
         IDLE: begin
            if (start) begin
               pc_nxt    = START_PC;
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            // Wait for start to fall so a held start never launches the program.
            if (!start) begin
               state_nxt   = RUN;
               running_nxt = 1'b1;
            end
         end
         RUN: begin
            if (halt) begin
               state_nxt   = HALTED;
               running_nxt = 1'b0;
               done_nxt    = 1'b1;
            end else if (br_taken && br_rel) begin
               pc_nxt = pc + off_ext;
            end else if (br_taken) begin
               pc_nxt = lut[br_lut_idx];
            end else if (pc == {PC_W{1'b1}}) begin
               // Falling off the top of memory: stop with a fault instead of wrapping silently.
               pc_nxt      = '0;
               fault_nxt   = 1'b1;
               done_nxt    = 1'b1;
               running_nxt = 1'b0;
               state_nxt   = HALTED;
            end else begin
               pc_nxt = pc + PC_W'(1);
            end
         end
         HALTED: begin
            if (start) begin
               done_nxt  = 1'b0;
               fault_nxt = 1'b0;
               pc_nxt    = START_PC;
               state_nxt = ARMED;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= START_PC;
         running <= 1'b0;
         done    <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         running <= running_nxt;
         done    <= done_nxt;
         fault   <= fault_nxt;
      end
   end

   // The LUT is frozen while a program is armed or running.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
      end else if (lut_we && lut_open) begin
         lut[lut_waddr] <= lut_wdata;
      end
   end

`ifdef PC_FETCH_ICOUNT_EN
   always_ff @(posedge clk) begin
      if (reset || start_accept) begin
         icount <= '0;
      end else if (state == RUN && icount != 16'hFFFF) begin
         icount <= icount + 16'd1;
      end
   end
`else
   logic unused_start_accept;
   assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb/tb_pc_fetch_seq.sv - directed self-checking bench for pc_fetch_seq
module tb_pc_fetch_seq;

   logic       clk = 1'b0;
   logic       reset, start, halt, br_taken, br_rel, lut_we;
   logic [3:0] br_lut_idx, lut_waddr;
   logic [5:0] br_off;
   logic [9:0] lut_wdata;
   logic [9:0] pc;
   logic       running, done, fault;
`ifdef PC_FETCH_ICOUNT_EN
   logic [15:0] icount;
`endif

   int checks = 0;
   int errors = 0;

   pc_fetch_seq dut (
`ifdef PC_FETCH_ICOUNT_EN
      .icount     (icount),
`endif
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .halt       (halt),
      .br_taken   (br_taken),
      .br_rel     (br_rel),
      .br_lut_idx (br_lut_idx),
      .br_off     (br_off),
      .lut_we     (lut_we),
      .lut_waddr  (lut_waddr),
      .lut_wdata  (lut_wdata),
      .pc         (pc),
      .running    (running),
      .done       (done),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic [9:0] epc, input logic erun,
                             input logic edone, input logic efault);
      chk({tag, "_pc"}, {22'd0, pc}, {22'd0, epc});
      chk({tag, "_running"}, {31'd0, running}, {31'd0, erun});
      chk({tag, "_done"}, {31'd0, done}, {31'd0, edone});
      chk({tag, "_fault"}, {31'd0, fault}, {31'd0, efault});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; halt = 1'b0; br_taken = 1'b0; br_rel = 1'b0;
      br_lut_idx = '0; br_off = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
      tick(); tick();
      reset = 1'b0;
      chk_status("reset", 10'h000, 1'b0, 1'b0, 1'b0);

      // Sequential run, halt at pc 5
      start = 1'b1; tick();
      chk_status("armed", 10'h000, 1'b0, 1'b0, 1'b0);
      start = 1'b0; tick();
      chk_status("run0", 10'h000, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("seq_pc%0d", i), {22'd0, pc}, i);
      end
      halt = 1'b1; tick(); halt = 1'b0;
      chk_status("halt5", 10'h005, 1'b0, 1'b1, 1'b0);
`ifdef PC_FETCH_ICOUNT_EN
      chk("icount_halt5", {16'd0, icount}, 32'd6);
`endif
      tick();
      chk_status("halt5_hold", 10'h005, 1'b0, 1'b1, 1'b0);

      // Back to IDLE; LUT write coinciding with start
      reset = 1'b1; tick(); reset = 1'b0;
      lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h040; start = 1'b1; tick();
      lut_we = 1'b0; start = 1'b0;
      chk_status("armed2", 10'h000, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk("run2_pc2", {22'd0, pc}, 32'h002);
      br_taken = 1'b1; br_rel = 1'b0; br_lut_idx = 4'd3; tick(); br_taken = 1'b0;
      chk("abs_branch", {22'd0, pc}, 32'h040);
      tick();
      chk("abs_next", {22'd0, pc}, 32'h041);

      // Relative branches: most-negative offset, then down to 0x010, 0x00D, 0x002, wrap to 0x3FF
      br_taken = 1'b1; br_rel = 1'b1;
      br_off = 6'b100000; tick();
      chk("rel_m32", {22'd0, pc}, 32'h021);
      br_off = 6'b101111; tick();
      chk("rel_m17", {22'd0, pc}, 32'h010);
      br_off = 6'b111101; tick();
      chk("rel_m3", {22'd0, pc}, 32'h00D);
      br_off = 6'b110101; tick();
      chk("rel_m11", {22'd0, pc}, 32'h002);
      br_off = 6'b111101; tick();
      chk_status("rel_wrap", 10'h3FF, 1'b1, 1'b0, 1'b0);
      br_off = 6'b000101; tick();
      chk("rel_p5", {22'd0, pc}, 32'h004);
      br_off = 6'b111011; tick();
      chk("rel_back", {22'd0, pc}, 32'h3FF);
      br_taken = 1'b0; br_rel = 1'b0;

      // Sequential advance from the top address faults
      tick();
      chk_status("wrap_fault", 10'h000, 1'b0, 1'b1, 1'b1);
      tick();
      chk_status("fault_hold", 10'h000, 1'b0, 1'b1, 1'b1);

      // Restart from HALTED with a held start: stays ARMED until start drops
      start = 1'b1; tick();
      chk_status("rearm", 10'h000, 1'b0, 1'b0, 1'b0);
      tick();
      chk_status("held_start", 10'h000, 1'b0, 1'b0, 1'b0);
      start = 1'b0; tick();
      chk_status("rerun", 10'h000, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++) tick();
      chk("rerun_pc7", {22'd0, pc}, 32'h007);

      // Halt wins over a same-edge branch
      halt = 1'b1; br_taken = 1'b1; br_rel = 1'b1; br_off = 6'b000101; tick();
      halt = 1'b0; br_taken = 1'b0; br_rel = 1'b0;
      chk_status("halt_vs_br", 10'h007, 1'b0, 1'b1, 1'b0);
`ifdef PC_FETCH_ICOUNT_EN
      chk("icount_halt7", {16'd0, icount}, 32'd8);
`endif

      // LUT write while RUN is ignored
      start = 1'b1; tick(); start = 1'b0; tick();
      chk_status("run3", 10'h000, 1'b1, 1'b0, 1'b0);
      lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h100; tick(); lut_we = 1'b0;
      chk("run3_pc1", {22'd0, pc}, 32'h001);
      br_taken = 1'b1; br_rel = 1'b0; br_lut_idx = 4'd3; tick();
      chk("lut_frozen", {22'd0, pc}, 32'h040);
      br_rel = 1'b1; br_off = 6'b100000; tick();
      chk("run3_pc20", {22'd0, pc}, 32'h020);

      // Reset mid-run beats a branch on the same edge and clears the LUT
      reset = 1'b1; br_rel = 1'b0; tick(); reset = 1'b0; br_taken = 1'b0;
      chk_status("mid_reset", 10'h000, 1'b0, 1'b0, 1'b0);
      tick();
      chk_status("mid_reset_idle", 10'h000, 1'b0, 1'b0, 1'b0);
      start = 1'b1; tick(); start = 1'b0; tick();
      br_taken = 1'b1; br_rel = 1'b0; br_lut_idx = 4'd3; tick(); tick();
      br_taken = 1'b0;
      chk("lut_cleared", {22'd0, pc}, 32'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Program-counter and fetch sequencer directly upstream of instruction memory and decode in the Program1 CPU top level.
- Runs a start/done handshake with the bench: idle until a start pulse, then issues one instruction address per cycle.
- Handles sequential advance, LUT-based absolute branches and signed relative branches.
- Stops on a decoded halt and raises done.

Parameters:
- PC_W, 10, program counter width in bits; instruction memory depth is 2^PC_W.
- LUT_AW, 4, branch-target LUT address width; the LUT has 2^LUT_AW entries of PC_W bits.
- OFF_W, 6, width of the signed relative branch offset.
- START_ADDR, 0, PC value loaded on start.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request from the bench, level-sampled.
- halt  in  1  decoded halt for the instruction currently at pc.
- br_taken  in  1  branch condition true for the current instruction.
- br_rel  in  1  selects the branch mode: 1 = relative (pc + offset), 0 = absolute via LUT.
- br_lut_idx  in  LUT_AW  LUT index for an absolute branch.
- br_off  in  OFF_W  signed two's-complement relative offset.
- lut_we  in  1  LUT write enable; honoured only in IDLE or HALTED.
- lut_waddr  in  LUT_AW  LUT write address.
- lut_wdata  in  PC_W  LUT write data.
- pc  out  PC_W  current instruction address, driven to instruction memory.
- running  out  1  high while in RUN.
- done  out  1  program finished (halt or fault).
- fault  out  1  PC wrapped past its top address without a halt.

Behaviour:
- States: IDLE, ARMED, RUN, HALTED. All outputs are registered.
- Reset: state IDLE; pc = START_ADDR; running = 0; done = 0; fault = 0. All LUT entries clear to 0.
- Reset asserted mid-run has priority over every other input on that edge.
- IDLE, start = 1: pc <= START_ADDR; go to ARMED. Otherwise hold.
- ARMED: wait for start = 0. On that edge go to RUN and set running = 1; pc holds START_ADDR.
  - A held start therefore never runs the program. The first instruction fetched is START_ADDR.
- RUN, priority on each edge:
  1. halt: go to HALTED; running <= 0; done <= 1; pc holds the halt address. Any br_taken on the same edge is ignored.
  2. br_taken & br_rel: pc <= pc + sign_extend(br_off), computed modulo 2^PC_W.
  3. br_taken & !br_rel: pc <= LUT[br_lut_idx].
  4. Otherwise: pc <= pc + 1.
- Wrap fault: sequential advance from pc = 2^PC_W-1 with no halt.
  - pc <= 0; fault <= 1; done <= 1; go to HALTED.
  - A relative branch that wraps is legal and does not set fault.
- HALTED:
  - pc, done and fault hold.
  - start = 1: done <= 0; fault <= 0; pc <= START_ADDR; go to ARMED (re-run without reset).
- Latency: one cycle from halt or the wrapping edge to done high.
- LUT writes:
  - Take effect on the clock edge and are readable from the next cycle.
  - lut_we is ignored in ARMED and RUN.
  - When a write and a start coincide in IDLE, both happen.
- Inputs halt, br_taken, br_rel, br_lut_idx and br_off are don't-care outside RUN.

Optional Feature:
- Macro: PC_FETCH_ICOUNT_EN.
- Defined: adds output icount [15:0].
  - Clears to 0 on reset and on the edge where start is accepted in IDLE or HALTED.
  - Increments on every RUN edge, including the halt edge; saturates at 16'hFFFF.
  - Holds in HALTED, so after a halt it equals the number of instructions executed.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start high for 1 cycle, then low; halt at pc = 5 -> pc sequence 0,0(ARMED),0,1,2,3,4,5; done = 1 one cycle after halt; pc holds 5; icount = 6.
- In IDLE write LUT[3] = 10'h040; run; at pc = 2 drive br_taken = 1, br_rel = 0, idx = 3 -> next pc = 0x040, then 0x041.
- Relative branch at pc = 0x010 with br_off = 6'b111101 (-3) -> pc = 0x00D. With pc = 0x002 and br_off = -3 -> pc = 0x3FF, fault stays 0.
- Drive halt and br_taken on the same edge at pc = 7 -> HALTED, pc = 7, branch ignored.
- Let pc reach 0x3FF with no halt -> pc = 0, fault = 1, done = 1. A later start pulse clears both flags and restarts from 0.
- Assert reset during RUN at pc = 0x020 -> next edge: pc = 0, IDLE, running = 0, done = 0. A lut_we pulse during RUN leaves the LUT unchanged (verified by a later absolute branch).
